// File: rtl/nibble_add_seq_if.sv
// Request/result and adder-slice signals of the nibble add/sub sequencer.
//   master : requesting datapath plus the external 4-bit adder slice
//            (drives start/sub/a/b/cin and the slice outputs add_s/add_co)
//   slave  : the sequencer (drives busy/done/sum/cout/ovf and add_a/add_b/add_cin)
interface nibble_add_seq_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_s;
  logic         add_co;

  modport master (
    output start, sub, a, b, cin, add_s, add_co,
    input  busy, done, sum, cout, ovf, add_a, add_b, add_cin
  );

  modport slave (
    input  start, sub, a, b, cin, add_s, add_co,
    output busy, done, sum, cout, ovf, add_a, add_b, add_cin
  );
endinterface

// File: rtl/nibble_add_seq.sv
// Multi-nibble add/subtract sequencer time-sharing one external 4-bit
// ripple-carry slice, least-significant nibble first, with SETTLE extra
// wait cycles per nibble before the slice result is sampled.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of nibble_add_seq_if
//                start/sub/a/b/cin -> request, busy/done -> status,
//                sum/cout/ovf -> result, add_a/add_b/add_cin -> slice inputs,
//                add_s/add_co -> slice outputs
module nibble_add_seq #(
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned SETTLE  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  nibble_add_seq_if.slave bus
);
  localparam int unsigned W        = 4 * NIBBLES;
  localparam int unsigned IW       = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST   = IW'(NIBBLES - 1);
  localparam logic [3:0] SETTLE_C  = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic [3:0]      cnt_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            ovf_q;
  logic            busy_q;
  logic            done_q;
  logic [3:0]      add_a_q;
  logic [3:0]      add_b_q;
  logic            add_cin_q;

  logic [W-1:0]    b_d;
  logic            carry_d;
  logic [IW-1:0]   idx_d;

  // Nibble i of a packed operand.
  function automatic logic [3:0] nib(input logic [W-1:0] v, input logic [IW-1:0] i);
    return 4'(v >> {i, 2'b00});
  endfunction

  // Operand B' and initial carry as latched on accept; subtraction is A + ~B + 1.
  always_comb begin
    b_d     = bus.sub ? ~bus.b : bus.b;
    carry_d = bus.sub ? 1'b1 : bus.cin;
    idx_d   = IW'(idx_q + 1'b1);
  end

  // Sequencer state, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q   <= RUN;
            a_q       <= bus.a;
            b_q       <= b_d;
            carry_q   <= carry_d;
            idx_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            add_a_q   <= bus.a[3:0];
            add_b_q   <= b_d[3:0];
            add_cin_q <= carry_d;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (cnt_q == SETTLE_C) begin
            for (int unsigned i = 0; i < NIBBLES; i++) begin
              if (idx_q == IW'(i)) sum_q[4*i +: 4] <= bus.add_s;
            end
            carry_q <= bus.add_co;
            cnt_q   <= '0;
            if (idx_q == LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cout_q  <= bus.add_co;
              // Overflow: operands agree in sign but the result does not.
              ovf_q   <= (a_q[W-1] == b_q[W-1]) && (bus.add_s[3] != a_q[W-1]);
            end else begin
              idx_q     <= idx_d;
              add_a_q   <= nib(a_q, idx_d);
              add_b_q   <= nib(b_q, idx_d);
              add_cin_q <= bus.add_co;
            end
          end else begin
            cnt_q <= 4'(cnt_q + 1'b1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
  assign bus.ovf     = ovf_q;
  assign bus.add_a   = add_a_q;
  assign bus.add_b   = add_b_q;
  assign bus.add_cin = add_cin_q;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq with a gate-delayed 4-bit slice model.
module tb_nibble_add_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   n_cyc;
  int   n_busy;
  logic cin_seen [4];

  always #50 clk = ~clk;

  nibble_add_seq_if #(.NIBBLES(4)) bus ();

  nibble_add_seq #(.NIBBLES(4), .SETTLE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Slice settles in 150 time units: longer than one period, shorter than two.
  logic [4:0] slice_r;
  assign #150 slice_r = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0, bus.add_cin};
  assign bus.add_s  = slice_r[3:0];
  assign bus.add_co = slice_r[4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [15:0] av, input logic [15:0] bv, input logic c);
    bus.sub = s;
    bus.a   = av;
    bus.b   = bv;
    bus.cin = c;
  endtask

  // Counts cycles after the accept edge until done is seen (bounded).
  task automatic wait_done(input bit pulse);
    bit got;
    got    = 1'b0;
    n_cyc  = 0;
    n_busy = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      n_cyc++;
      if (bus.busy) n_busy++;
      if (n_cyc % 2 == 0 && n_cyc <= 8) cin_seen[n_cyc/2 - 1] = bus.add_cin;
      if (pulse) begin
        if (n_cyc == 3) begin
          bus.start = 1'b1;
          drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        end
        if (n_cyc == 4) bus.start = 1'b0;
      end
      if (bus.done) got = 1'b1;
    end
  endtask

  task automatic do_op(input logic s, input logic [15:0] av, input logic [15:0] bv,
                       input logic c, input bit pulse);
    @(negedge clk);
    drive(s, av, bv, c);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(pulse);
  endtask

  initial begin
    bus.start = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.busy, bus.done, bus.cout, bus.ovf, bus.add_cin,
                            bus.add_a, bus.add_b, bus.sum}, 64'h0);
    rst_n = 1'b1;

    // 0 + 0
    do_op(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("zero_done_cycle", 64'(n_cyc), 64'd9);
    check("zero_busy_cycles", 64'(n_busy), 64'd8);
    check("zero_result", {bus.cout, bus.ovf, bus.sum}, {2'b00, 16'h0000});

    // FFFF + 0001: carry ripples through all nibbles
    do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("ffff_sum", bus.sum, 16'h0000);
    check("ffff_cout_ovf", {bus.cout, bus.ovf}, 2'b10);
    check("ffff_add_cin", {cin_seen[0], cin_seen[1], cin_seen[2], cin_seen[3]}, 4'b0111);

    // 7FFF + 0001: signed overflow
    do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("ovf_sum", bus.sum, 16'h8000);
    check("ovf_cout_ovf", {bus.cout, bus.ovf}, 2'b01);

    // 1234 + 4321 + 1
    do_op(1'b0, 16'h1234, 16'h4321, 1'b1, 1'b0);
    check("cin_sum", bus.sum, 16'h5556);
    check("cin_cout_ovf", {bus.cout, bus.ovf}, 2'b00);

    // 1234 - 1235 with cin=1 ignored: borrow
    do_op(1'b1, 16'h1234, 16'h1235, 1'b1, 1'b0);
    check("sub_borrow_sum", bus.sum, 16'hFFFF);
    check("sub_borrow_cout_ovf", {bus.cout, bus.ovf}, 2'b00);

    // 5000 - 1000: no borrow
    do_op(1'b1, 16'h5000, 16'h1000, 1'b0, 1'b0);
    check("sub_sum", bus.sum, 16'h4000);
    check("sub_cout_ovf", {bus.cout, bus.ovf}, 2'b10);

    // start pulse during busy is ignored
    do_op(1'b0, 16'h0F0F, 16'h0101, 1'b0, 1'b1);
    check("ignore_done_cycle", 64'(n_cyc), 64'd9);
    check("ignore_sum", bus.sum, 16'h1010);
    @(negedge clk);
    check("ignore_idle_after", {bus.busy, bus.done, bus.sum}, {2'b00, 16'h1010});

    // back-to-back: start held through done
    @(negedge clk);
    drive(1'b0, 16'h0001, 16'h0002, 1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    #1 drive(1'b0, 16'h8000, 16'h8000, 1'b0);
    wait_done(1'b0);
    check("b2b_first_sum", {bus.cout, bus.ovf, bus.sum}, {2'b00, 16'h0003});
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(1'b0);
    check("b2b_second_done_cycle", 64'(n_cyc), 64'd9);
    check("b2b_second_busy_cycles", 64'(n_busy), 64'd8);
    check("b2b_second_result", {bus.cout, bus.ovf, bus.sum}, {2'b11, 16'h0000});

    // reset during nibble 2
    @(negedge clk);
    drive(1'b0, 16'h1111, 16'h2222, 1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", bus.busy, 1'b1);
    #10 rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {bus.busy, bus.done, bus.cout, bus.ovf, bus.add_cin,
                                bus.add_a, bus.add_b, bus.sum}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {bus.busy, bus.done}, 2'b00);
    do_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    check("post_reset_done_cycle", 64'(n_cyc), 64'd9);
    check("post_reset_result", {bus.cout, bus.sum}, {1'b0, 16'h0100});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Sequencer that performs multi-nibble addition and subtraction by time-sharing one external 4-bit ripple-carry adder slice. It walks the operands least-significant nibble first, one nibble per step, and feeds the slice's carry-out back as the next carry-in. It holds each nibble for a programmable settle time so the gate-delayed slice can resolve. It sits between a requesting datapath (start/done handshake) and the 4-bit adder instance.

## Interface
- NIBBLES, default 4: operand width in nibbles; the operand width is 4*NIBBLES bits. Legal range is 1 to 16.
- SETTLE, default 1: extra wait cycles per nibble before sampling the slice. Legal range is 0 to 15.

Ports (clock and reset first):
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request. Sampled only in IDLE or DONE.
- sub  in  1  0 = A+B+cin; 1 = A−B, where B is inverted and the initial carry is 1, and cin is ignored.
- a  in  4*NIBBLES  operand A, latched on accept.
- b  in  4*NIBBLES  operand B, latched on accept.
- cin  in  1  carry-in for add, latched on accept.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- sum  out  4*NIBBLES  result, held until the next accept.
- cout  out  1  final carry. For sub, 1 means no borrow.
- ovf  out  1  two's-complement overflow of the final result.
- add_a  out  4  nibble of A presented to the slice.
- add_b  out  4  nibble of B, or of ~B when sub=1, presented to the slice.
- add_cin  out  1  carry presented to the slice.
- add_s  in  4  slice sum.
- add_co  in  1  slice carry-out.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when start=1:
  - Latch a, b (inverted if sub), and sub.
  - Set the carry register to (sub ? 1 : cin).
  - Set nibble index = 0 and wait counter = 0.
- RUN:
  - add_a/add_b are driven from the latched nibble at the current index. add_cin is driven from the carry register. All three are registered outputs.
  - The wait counter counts 0..SETTLE.
  - When the counter equals SETTLE:
    - add_s is written into sum nibble [index].
    - The carry register takes add_co.
    - The index increments and the counter clears.
  - On the last nibble (index = NIBBLES−1), the state goes to DONE instead of incrementing.
- DONE:
  - done=1 for exactly one cycle.
  - On entry to DONE, cout is set to the final add_co.
  - On entry to DONE, ovf is set to (A[msb] == B'[msb]) && (S[msb] != A[msb]), using the latched (possibly inverted) B'.
  - If start=1 in this cycle, the request is accepted exactly as from IDLE (back-to-back) and the state goes to RUN. Otherwise the state goes to IDLE.
- start in RUN is ignored; no queuing.
- Slice inputs hold stable for SETTLE+1 cycles per nibble, and the captured value never comes from the first cycle of a new nibble.
- sum, cout and ovf change only at nibble capture and DONE entry. They are stable from done until the next accept.
- Reset (any time, including mid-RUN):
  - Outputs clear immediately: busy, done, sum, cout, ovf, add_a, add_b and add_cin are all 0.
  - State goes to IDLE; index, counter and the carry register clear.
  - The partial result is discarded.

## Timing
- Accept edge = E0. busy=1 from E0 until the edge that enters DONE.
- Nibble k is captured at edge E0 + (k+1)*(SETTLE+1).
- DONE is entered at E0 + NIBBLES*(SETTLE+1), and done is high during the following cycle. busy=0 in DONE.
- Defaults (NIBBLES=4, SETTLE=1): 8 busy cycles, with done in cycle 9.
- Back-to-back throughput: one operation every NIBBLES*(SETTLE+1)+1 cycles.
- The slice's combinational delay must be shorter than (SETTLE+1) clock periods. Benches use a clock period of at least 100 time units.
- With SETTLE=0, each nibble is captured one cycle after it is presented.

## Test plan
- Reset, then a=0x0000, b=0x0000, cin=0, sub=0 → done in cycle 9 after accept; sum=0x0000, cout=0, ovf=0. All outputs read 0 during reset.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. add_cin=1 is observed on nibbles 1–3.
- a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1. Separately, a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0.
- sub=1, a=0x1234, b=0x1235, cin=1 → sum=0xFFFF, cout=0, and cin is ignored. Then sub=1, a=0x5000, b=0x1000 → sum=0x4000, cout=1.
- Start pulses are issued during busy and ignored; the result is unchanged. start is held high through done → the second operation is accepted at the done edge, with no IDLE cycle, and produces the correct result.
- rst_n is asserted low during nibble 2 of an op → outputs are 0 asynchronously and the block returns to IDLE. A subsequent op 0x00FF+0x0001 gives 0x0100, cout=0.
